pc_unit: RTL

//  Program-counter stage directly upstream of instruction_fetcher: owns the architectural PC
//  and drives instruction_fetcher.pc each cycle. Computes next PC from sequential/branch/jump/

---
 rtl/pc_unit_if.sv | 32 +++
 rtl/pc_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Request/status bundle between decode/execute and the program-counter stage.
// The master drives redirect requests; the slave (pc_unit) returns PC and status.
interface pc_unit_if #(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic              branch_en;
  logic [PC_W-1:0]   branch_off;
  logic              jump_en;
  logic              call_en;
  logic [PC_W-1:0]   jump_target;
  logic              ret_en;
  logic              halt_req;
  logic [PC_W-1:0]   pc;
  logic              halted;
  logic              fault;
  logic [CNT_W-1:0]  ras_count;
  logic [31:0]       instr_count;

  modport master (
    output stall, branch_en, branch_off, jump_en, call_en, jump_target, ret_en, halt_req,
    input  pc, halted, fault, ras_count, instr_count
  );

  modport slave (
    input  stall, branch_en, branch_off, jump_en, call_en, jump_target, ret_en, halt_req,
    output pc, halted, fault, ras_count, instr_count
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage: owns the architectural PC, resolves redirects by priority,
// keeps a circular return-address stack and a sticky halt/fault state machine.
//
//  state | meaning
//  RUN   | PC advances or redirects once per cycle unless stalled
//  HALT  | halt requested; everything frozen until reset
//  FAULT | misaligned target or RAS underflow; frozen until reset
module pc_unit #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_unit_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       instr_q;
  logic              push;
  logic              adv;
  logic [PC_W-1:0]   link;
  logic [PC_W-1:0]   ret_addr;
  logic [PC_W-1:0]   ras [RAS_DEPTH];

  assign link     = pc_q + PC_W'(4);
  assign ret_addr = ras[wp_q - PTR_W'(1)];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    adv     = 1'b0;
    if (state_q == RUN) begin
      if (bus.halt_req) begin
        state_d = HALT;
      end else if (!bus.stall) begin
        if (bus.ret_en) begin
          if (cnt_q == '0 || ret_addr[1:0] != 2'b00) begin
            state_d = FAULT;
          end else begin
            pc_d  = ret_addr;
            wp_d  = wp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
            adv   = 1'b1;
          end
        end else if (bus.call_en) begin
          if (bus.jump_target[1:0] != 2'b00) begin
            state_d = FAULT;
          end else begin
            pc_d  = bus.jump_target;
            push  = 1'b1;
            // a full stack keeps its count; the write lands on the oldest slot
            wp_d  = wp_q + PTR_W'(1);
            cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
            adv   = 1'b1;
          end
        end else if (bus.jump_en) begin
          if (bus.jump_target[1:0] != 2'b00) state_d = FAULT;
          else begin
            pc_d = bus.jump_target;
            adv  = 1'b1;
          end
        end else if (bus.branch_en) begin
          if (((pc_q + bus.branch_off) & PC_W'(3)) != '0) state_d = FAULT;
          else begin
            pc_d = pc_q + bus.branch_off;
            adv  = 1'b1;
          end
        end else begin
          pc_d = link;
          adv  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      wp_q    <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      if (adv) instr_q <= instr_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) ras[wp_q] <= link;
  end

  assign bus.pc          = pc_q;
  assign bus.halted      = (state_q != RUN);
  assign bus.fault       = (state_q == FAULT);
  assign bus.ras_count   = cnt_q;
  assign bus.instr_count = instr_q;
endmodule
